// File: rtl/pipe_alu_datapath.sv
// Three-stage register/ALU datapath: RD (regfile read + forwarding), EX (ALU), WB (regfile write).
// One instruction per cycle, full forwarding from EX and WB, external stall and EX-stage flush.
module pipe_alu_datapath #(
   parameter  int WIDTH = 32,
   parameter  int NREGS = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    in_rs,
   input  logic [AW-1:0]    in_rt,
   input  logic [AW-1:0]    in_rd,
   input  logic [15:0]      in_imm,
   input  logic             in_imm_zext,
   input  logic             in_src_b,
   input  logic [2:0]       in_alu_op,
   input  logic             in_reg_write,
   input  logic             stall,
   input  logic             flush,
   output logic             out_valid,
   output logic [AW-1:0]    out_rd,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_overflow,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);
   localparam int SW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_regs [NREGS];

   logic             r_s1_valid, r_s1_we;
   logic [AW-1:0]    r_s1_rd;
   logic [2:0]       r_s1_op;
   logic [WIDTH-1:0] r_s1_a, r_s1_b;

   logic             r_s2_valid, r_s2_we, r_s2_zero, r_s2_ovf;
   logic [AW-1:0]    r_s2_rd;
   logic [WIDTH-1:0] r_s2_result;

   logic             w_acc, w_s1_fwd, w_s2_fwd, w_ex_ovf, w_s1_adv;
   logic signed [15:0] w_imm_s;
   logic [WIDTH-1:0] w_imm_ext, w_a, w_b_reg, w_b, w_ex_result, w_sum, w_diff;

   assign in_ready = ~stall & ~flush;
   assign w_acc    = in_valid & in_ready;
   assign w_s1_adv = r_s1_valid & ~flush;

   assign w_imm_s   = in_imm;
   assign w_imm_ext = in_imm_zext ? WIDTH'(in_imm) : WIDTH'(w_imm_s);

   // Youngest producer wins; register 0 is never forwarded.
   assign w_s1_fwd = r_s1_valid & r_s1_we;
   assign w_s2_fwd = r_s2_valid & r_s2_we;
   assign w_a      = (in_rs == '0) ? '0 :
                     (w_s1_fwd && r_s1_rd == in_rs) ? w_ex_result :
                     (w_s2_fwd && r_s2_rd == in_rs) ? r_s2_result : r_regs[in_rs];
   assign w_b_reg  = (in_rt == '0) ? '0 :
                     (w_s1_fwd && r_s1_rd == in_rt) ? w_ex_result :
                     (w_s2_fwd && r_s2_rd == in_rt) ? r_s2_result : r_regs[in_rt];
   assign w_b      = in_src_b ? w_imm_ext : w_b_reg;

   assign w_sum  = r_s1_a + r_s1_b;
   assign w_diff = r_s1_a - r_s1_b;

   always_comb begin
      w_ex_result = '0;
      w_ex_ovf    = 1'b0;
      case (r_s1_op)
         3'b000: w_ex_result = r_s1_a & r_s1_b;
         3'b001: w_ex_result = r_s1_a | r_s1_b;
         3'b010: begin
            w_ex_result = w_sum;
            w_ex_ovf    = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
         end
         3'b011: w_ex_result = r_s1_a ^ r_s1_b;
         3'b100: w_ex_result = ~(r_s1_a | r_s1_b);
         3'b101: w_ex_result = r_s1_a >> r_s1_b[SW-1:0];
         3'b110: begin
            w_ex_result = w_diff;
            w_ex_ovf    = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
         end
         default: w_ex_result = {{(WIDTH-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_we     <= 1'b0;
         r_s1_rd     <= '0;
         r_s1_op     <= '0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_we     <= 1'b0;
         r_s2_zero   <= 1'b0;
         r_s2_ovf    <= 1'b0;
         r_s2_rd     <= '0;
         r_s2_result <= '0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         if (flush) begin
            r_s1_valid <= 1'b0;
         end else if (!stall) begin
            r_s1_valid <= w_acc;
            if (w_acc) begin
               r_s1_we <= in_reg_write;
               r_s1_rd <= in_rd;
               r_s1_op <= in_alu_op;
               r_s1_a  <= w_a;
               r_s1_b  <= w_b;
            end
         end
         // A flushed EX instruction becomes a bubble instead of moving to WB.
         if (!stall) begin
            r_s2_valid <= w_s1_adv;
            if (w_s1_adv) begin
               r_s2_we     <= r_s1_we;
               r_s2_rd     <= r_s1_rd;
               r_s2_result <= w_ex_result;
               r_s2_zero   <= (w_ex_result == '0);
               r_s2_ovf    <= w_ex_ovf;
            end
            if (r_s2_valid && r_s2_we && r_s2_rd != '0) r_regs[r_s2_rd] <= r_s2_result;
         end
      end
   end

   assign out_valid    = r_s2_valid;
   assign out_rd       = r_s2_rd;
   assign out_result   = r_s2_result;
   assign out_zero     = r_s2_zero;
   assign out_overflow = r_s2_ovf;
   assign dbg_data     = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
endmodule

// File: tb/tb_pipe_alu_datapath.sv
// Bench for pipe_alu_datapath: directed scenarios plus random traffic checked against a
// sequential (one-instruction-at-a-time) ISA model that executes each instruction as it retires.
module tb_pipe_alu_datapath;
   localparam int W = 32, N = 32, AW = 5;

   logic clk = 1'b0, rst;
   logic in_valid, in_ready, in_imm_zext, in_src_b, in_reg_write, stall, flush;
   logic [AW-1:0] in_rs, in_rt, in_rd, out_rd, dbg_addr;
   logic [15:0] in_imm;
   logic [2:0] in_alu_op;
   logic out_valid, out_zero, out_overflow;
   logic [W-1:0] out_result, dbg_data;

   pipe_alu_datapath #(.WIDTH(W), .NREGS(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_imm_zext(in_imm_zext), .in_src_b(in_src_b), .in_alu_op(in_alu_op),
      .in_reg_write(in_reg_write), .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_rd(out_rd), .out_result(out_result),
      .out_zero(out_zero), .out_overflow(out_overflow),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data));

   always #5 clk = ~clk;

   typedef struct packed {
      logic v;
      logic [4:0] rs, rt, rd;
      logic [15:0] imm;
      logic zext, srcb;
      logic [2:0] op;
      logic we;
   } ins_t;

   int checks = 0, errors = 0;
   logic [W-1:0] mregs [N];
   ins_t pend[$];
   logic [W-1:0] ret_log[$];
   bit ovf_log[$];
   bit young_s1 = 0;
   ins_t NOP = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ins_t mk(input logic [2:0] op, input logic [4:0] rd, rs, rt,
                               input logic [15:0] imm, input logic srcb, zext);
      ins_t i;
      i = '{v:1'b1, rs:rs, rt:rt, rd:rd, imm:imm, zext:zext, srcb:srcb, op:op, we:1'b1};
      return i;
   endfunction

   // Architectural semantics, evaluated against the retired register state.
   function automatic void exec(input ins_t i, output logic [W-1:0] r, output bit ov);
      logic [W-1:0] a, b;
      longint sa, sb, s;
      a = (i.rs == 0) ? '0 : mregs[i.rs];
      if (i.srcb) b = i.zext ? {16'h0, i.imm} : {{16{i.imm[15]}}, i.imm};
      else        b = (i.rt == 0) ? '0 : mregs[i.rt];
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ov = 0;
      r  = '0;
      case (i.op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin s = sa + sb; r = a + b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         3'd3: r = a ^ b;
         3'd4: r = ~(a | b);
         3'd5: r = a >> b[4:0];
         3'd6: begin s = sa - sb; r = a - b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         default: r = (sa < sb) ? 1 : 0;
      endcase
   endfunction

   task automatic cyc(input ins_t i, input bit st, input bit fl);
      ins_t h;
      logic [W-1:0] er, s_res;
      logic [AW-1:0] s_rd;
      logic s_v;
      bit eo;
      @(negedge clk);
      in_valid = i.v; in_rs = i.rs; in_rt = i.rt; in_rd = i.rd; in_imm = i.imm;
      in_imm_zext = i.zext; in_src_b = i.srcb; in_alu_op = i.op; in_reg_write = i.we;
      stall = st; flush = fl;
      #1;
      chk("in_ready", in_ready, !st && !fl);
      if (out_valid && !st) begin
         chk("retire_expected", pend.size() > 0, 1);
         if (pend.size() > 0) begin
            h = pend.pop_front();
            exec(h, er, eo);
            chk("out_rd", out_rd, h.rd);
            chk("out_result", out_result, er);
            chk("out_overflow", out_overflow, eo);
            chk("out_zero", out_zero, er == 0);
            if (h.we && h.rd != 0) mregs[h.rd] = er;
            ret_log.push_back(er);
            ovf_log.push_back(eo);
         end
      end
      s_v = out_valid; s_res = out_result; s_rd = out_rd;
      if (fl) begin
         if (young_s1) h = pend.pop_back();
         young_s1 = 0;
      end else if (!st) young_s1 = 0;
      if (i.v && !st && !fl) begin pend.push_back(i); young_s1 = 1; end
      @(posedge clk); #1;
      if (st) begin
         chk("stall_hold_valid", out_valid, s_v);
         chk("stall_hold_result", out_result, s_res);
         chk("stall_hold_rd", out_rd, s_rd);
      end
   endtask

   task automatic drain();
      repeat (4) cyc(NOP, 0, 0);
      chk("drain_empty", pend.size(), 0);
   endtask

   task automatic chk_regs();
      for (int r = 0; r < N; r++) begin
         dbg_addr = AW'(r); #1;
         chk($sformatf("reg%0d", r), dbg_data, mregs[r]);
      end
   endtask

   task automatic clr_log();
      ret_log.delete(); ovf_log.delete();
   endtask

   initial begin
      ins_t ri;
      for (int r = 0; r < N; r++) mregs[r] = '0;
      rst = 1; in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0; in_imm_zext = 0;
      in_src_b = 0; in_alu_op = 0; in_reg_write = 0; stall = 0; flush = 0; dbg_addr = 0;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_result", out_result, 0);
      chk("rst_zero", out_zero, 0);
      chk("rst_ovf", out_overflow, 0);
      dbg_addr = 5; #1;
      chk("rst_dbg", dbg_data, 0);
      @(negedge clk); rst = 0;

      // add r8=r0+r0, ori r9=r0|0xF
      clr_log();
      cyc(mk(3'd2, 8, 0, 0, 0, 0, 0), 0, 0);
      cyc(mk(3'd1, 9, 0, 0, 16'h000F, 1, 1), 0, 0);
      drain();
      chk("t1_n", ret_log.size(), 2);
      chk("t1_r0", ret_log[0], 0);
      chk("t1_r1", ret_log[1], 32'hF);
      dbg_addr = 9; #1;
      chk("t1_dbg_r9", dbg_data, 32'hF);

      // forwarding chain
      clr_log();
      cyc(mk(3'd1, 9, 0, 0, 16'h000F, 1, 1), 0, 0);
      cyc(mk(3'd2, 10, 9, 0, 16'h0001, 1, 0), 0, 0);
      cyc(mk(3'd6, 11, 10, 9, 0, 0, 0), 0, 0);
      drain();
      chk("t2_n", ret_log.size(), 3);
      chk("t2_r1", ret_log[1], 32'h10);
      chk("t2_r2", ret_log[2], 32'h1);

      // nor / srl / add overflow / slt
      clr_log();
      cyc(mk(3'd4, 2, 0, 0, 0, 0, 0), 0, 0);
      cyc(mk(3'd5, 3, 2, 0, 16'h0001, 1, 1), 0, 0);
      cyc(mk(3'd2, 4, 3, 3, 0, 0, 0), 0, 0);
      cyc(mk(3'd7, 5, 2, 0, 0, 0, 0), 0, 0);
      drain();
      chk("t3_n", ret_log.size(), 4);
      chk("t3_nor", ret_log[0], 32'hFFFFFFFF);
      chk("t3_srl", ret_log[1], 32'h7FFFFFFF);
      chk("t3_add", ret_log[2], 32'hFFFFFFFE);
      chk("t3_ovf", ovf_log[2], 1);
      chk("t3_slt", ret_log[3], 1);

      // writes to r0
      clr_log();
      cyc(mk(3'd2, 0, 0, 0, 16'h0005, 1, 0), 0, 0);
      cyc(mk(3'd2, 6, 0, 0, 0, 0, 0), 0, 0);
      drain();
      chk("t4_r0res", ret_log[0], 5);
      chk("t4_r6", ret_log[1], 0);
      dbg_addr = 0; #1;
      chk("t4_dbg_r0", dbg_data, 0);

      // stall mid-flight
      clr_log();
      cyc(mk(3'd2, 12, 0, 0, 16'h0007, 1, 0), 0, 0);
      cyc(mk(3'd2, 13, 12, 0, 16'h0003, 1, 0), 0, 0);
      cyc(mk(3'd2, 14, 13, 12, 0, 0, 0), 0, 0);
      cyc(NOP, 1, 0);
      cyc(NOP, 1, 0);
      drain();
      chk("t5_n", ret_log.size(), 3);
      chk("t5_r14", ret_log[2], 17);

      // flush the EX instruction while an older one sits in WB
      clr_log();
      cyc(mk(3'd2, 16, 0, 0, 16'h0009, 1, 0), 0, 0);
      cyc(mk(3'd2, 15, 0, 0, 16'h0055, 1, 0), 0, 0);
      cyc(NOP, 0, 1);
      drain();
      chk("t6_n", ret_log.size(), 1);
      chk("t6_r16", ret_log[0], 9);
      chk_regs();

      // asynchronous reset mid-flight
      cyc(mk(3'd2, 20, 0, 0, 16'h0003, 1, 0), 0, 0);
      cyc(mk(3'd2, 21, 0, 0, 16'h0004, 1, 0), 0, 0);
      #1 rst = 1; in_valid = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_result", out_result, 0);
      for (int r = 0; r < N; r++) mregs[r] = '0;
      pend.delete(); young_s1 = 0;
      chk_regs();
      @(negedge clk); rst = 0;

      // random traffic with heavy register reuse
      for (int n = 0; n < 500; n++) begin
         ri.v    = ($urandom_range(0, 3) != 0);
         ri.rs   = 5'($urandom_range(0, 7));
         ri.rt   = 5'($urandom_range(0, 7));
         ri.rd   = 5'($urandom_range(0, 7));
         ri.imm  = 16'($urandom);
         ri.zext = 1'($urandom);
         ri.srcb = 1'($urandom);
         ri.op   = 3'($urandom);
         ri.we   = ($urandom_range(0, 4) != 0);
         cyc(ri, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
      end
      drain();
      chk_regs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
